// File: rtl/fxu_pipe.sv
// Fixed-point execute unit: one-entry issue stage (S1), multi-cycle MUL FSM,
// and an in-order result FIFO with valid/ready handshakes on both sides.
module fxu_pipe #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ROB_BITS   = 4,
  parameter int unsigned IMM_BITS   = 8,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_opcode,
  input  logic [ROB_BITS-1:0] in_index,
  input  logic [WIDTH-1:0]    in_va,
  input  logic [WIDTH-1:0]    in_vb,
  input  logic [IMM_BITS-1:0] in_i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROB_BITS-1:0] out_rob_index,
  output logic [WIDTH-1:0]    out_return_value
);

  localparam int unsigned ShW  = $clog2(WIDTH);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned McW  = $clog2(MUL_CYCLES);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpMov  = 4'b0100;
  localparam logic [3:0] OpMovl = 4'b0101;
  localparam logic [3:0] OpMovh = 4'b0110;
  localparam logic [3:0] OpShl  = 4'b0111;
  localparam logic [3:0] OpMul  = 4'b1000;

  typedef enum logic {StIdle, StMul} state_e;

  state_e              state_q, state_d;
  logic [McW-1:0]      mcnt_q, mcnt_d;

  logic                s1_valid_q, s1_valid_d;
  logic [3:0]          s1_op_q, s1_op_d;
  logic [ROB_BITS-1:0] s1_idx_q, s1_idx_d;
  logic [WIDTH-1:0]    s1_va_q, s1_va_d;
  logic [WIDTH-1:0]    s1_vb_q, s1_vb_d;
  logic [IMM_BITS-1:0] s1_i_q, s1_i_d;

  logic [WIDTH-1:0]    val_q [DEPTH];
  logic [WIDTH-1:0]    val_d [DEPTH];
  logic [ROB_BITS-1:0] rob_q [DEPTH];
  logic [ROB_BITS-1:0] rob_d [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]    s1_res;
  logic [CntW:0]       occ;
  logic                push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    s1_res = '0;
    case (s1_op_q)
      OpAdd:   s1_res = s1_va_q + s1_vb_q;
      OpSub:   s1_res = s1_va_q - s1_vb_q;
      OpAnd:   s1_res = s1_va_q & s1_vb_q;
      OpOr:    s1_res = s1_va_q | s1_vb_q;
      OpMov:   s1_res = s1_va_q;
      OpMovl:  s1_res = {s1_va_q[WIDTH-1:IMM_BITS], s1_i_q};
      OpMovh:  s1_res = {s1_i_q, s1_va_q[WIDTH-IMM_BITS-1:0]};
      OpShl:   s1_res = s1_va_q << s1_vb_q[ShW-1:0];
      OpMul:   s1_res = s1_va_q * s1_vb_q;
      default: s1_res = '0;
    endcase
  end

  // Occupancy counts S1 as a reserved FIFO slot so a push can never overflow.
  always_comb begin
    occ       = {1'b0, cnt_q} + {{CntW{1'b0}}, s1_valid_q};
    in_ready  = (state_q == StIdle) && !(s1_valid_q && (s1_op_q == OpMul)) &&
                (occ < (CntW + 1)'(DEPTH));
    out_valid = (cnt_q != '0);
    out_rob_index    = out_valid ? rob_q[rd_ptr_q] : '0;
    out_return_value = out_valid ? val_q[rd_ptr_q] : '0;
  end

  always_comb begin
    state_d    = state_q;
    mcnt_d     = mcnt_q;
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_idx_d   = s1_idx_q;
    s1_va_d    = s1_va_q;
    s1_vb_d    = s1_vb_q;
    s1_i_d     = s1_i_q;
    val_d      = val_q;
    rob_d      = rob_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    pop        = out_valid && out_ready;

    if (state_q == StIdle) begin
      if (s1_valid_q) begin
        if (s1_op_q == OpMul) begin
          state_d = StMul;
          mcnt_d  = McW'(1);
        end else begin
          push       = 1'b1;
          s1_valid_d = 1'b0;
        end
      end
    end else begin
      if (mcnt_q == McW'(MUL_CYCLES - 1)) begin
        push       = 1'b1;
        s1_valid_d = 1'b0;
        state_d    = StIdle;
        mcnt_d     = '0;
      end else begin
        mcnt_d = mcnt_q + 1'b1;
      end
    end

    if (in_valid && in_ready) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_opcode;
      s1_idx_d   = in_index;
      s1_va_d    = in_va;
      s1_vb_d    = in_vb;
      s1_i_d     = in_i;
    end

    if (push) begin
      val_d[wr_ptr_q] = s1_res;
      rob_d[wr_ptr_q] = s1_idx_q;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Flush squashes everything, including any accept or pop this cycle.
    if (flush) begin
      state_d    = StIdle;
      mcnt_d     = '0;
      s1_valid_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      mcnt_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_idx_q   <= '0;
      s1_va_q    <= '0;
      s1_vb_q    <= '0;
      s1_i_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        val_q[k] <= '0;
        rob_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mcnt_q     <= mcnt_d;
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_idx_q   <= s1_idx_d;
      s1_va_q    <= s1_va_d;
      s1_vb_q    <= s1_vb_d;
      s1_i_q     <= s1_i_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      val_q      <= val_d;
      rob_q      <= rob_d;
    end
  end

endmodule

// File: tb/tb_fxu_pipe.sv
// Bench for fxu_pipe: directed scenarios plus a random stream, all results checked
// against an in-order queue of expected values computed from the opcode rules.
module tb_fxu_pipe;

  localparam int unsigned W   = 16;
  localparam int unsigned IMM = 8;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [3:0]  in_index;
  logic [15:0] in_va;
  logic [15:0] in_vb;
  logic [7:0]  in_i;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_rob_index;
  logic [15:0] out_return_value;

  fxu_pipe dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_opcode        (in_opcode),
    .in_index         (in_index),
    .in_va            (in_va),
    .in_vb            (in_vb),
    .in_i             (in_i),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_rob_index    (out_rob_index),
    .out_return_value (out_return_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rob;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          n_pops = 0;
  logic        prev_stall = 1'b0;
  logic [3:0]  prev_rob;
  logic [15:0] prev_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Opcode semantics as plain modular arithmetic.
  function automatic logic [15:0] ref_res(input logic [3:0] op, input int unsigned a,
                                          input int unsigned b, input int unsigned i);
    int unsigned mask;
    int unsigned lo_mask;
    int unsigned r;
    mask    = (1 << W) - 1;
    lo_mask = (1 << (W - IMM)) - 1;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a;
      4'd5:    r = (a & (mask ^ ((1 << IMM) - 1))) | i;
      4'd6:    r = (i << (W - IMM)) | (a & lo_mask);
      4'd7:    r = a << (b % W);
      4'd8:    r = a * b;
      default: r = 0;
    endcase
    r = r & mask;
    return r[15:0];
  endfunction

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] idx,
                       input logic [15:0] va, input logic [15:0] vb, input logic [7:0] i);
    in_valid  = v;
    in_opcode = op;
    in_index  = idx;
    in_va     = va;
    in_vb     = vb;
    in_i      = i;
  endtask

  // Sample at the falling edge, update the scoreboard, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (prev_stall) begin
      chk("stable_valid", 32'(out_valid), 32'd1);
      chk("stable_rob", 32'(out_rob_index), 32'(prev_rob));
      chk("stable_val", 32'(out_return_value), 32'(prev_val));
    end
    if (exp_q.size() == 0) chk("no_stale", 32'(out_valid), 32'd0);
    if (!out_valid) chk("empty_zero", {12'd0, out_rob_index, out_return_value}, 32'd0);
    if (reset || flush) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_pops++;
        chk("out_rob", 32'(out_rob_index), 32'(e.rob));
        chk("out_val", 32'(out_return_value), 32'(e.val));
      end
      if (in_valid && in_ready) begin
        e.rob = in_index;
        e.val = ref_res(in_opcode, 32'(in_va), 32'(in_vb), 32'(in_i));
        exp_q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_rob   = out_rob_index;
      prev_val   = out_return_value;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pops0;
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 4'd0, 4'd0, 16'd0, 16'd0, 8'd0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rob", 32'(out_rob_index), 32'd0);
    chk("rst_val", 32'(out_return_value), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD wraps; visible two edges after accept, for one cycle.
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 4'd3, 16'hFFFF, 16'h0002, 8'h00);
    tick();
    in_valid = 1'b0;
    chk("add_not_yet", 32'(out_valid), 32'd0);
    tick();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_val", 32'(out_return_value), 32'h0001);
    chk("add_rob", 32'(out_rob_index), 32'd3);
    tick();
    chk("add_one_cycle", 32'(out_valid), 32'd0);

    // MOVL then MOVH back-to-back.
    drive(1'b1, 4'd5, 4'd5, 16'hABCD, 16'h0000, 8'h12);
    tick();
    chk("movh_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 4'd6, 4'd6, 16'hABCD, 16'h0000, 8'h12);
    tick();
    in_valid = 1'b0;
    chk("movl_val", 32'(out_return_value), 32'hAB12);
    chk("movl_rob", 32'(out_rob_index), 32'd5);
    tick();
    chk("movh_valid", 32'(out_valid), 32'd1);
    chk("movh_val", 32'(out_return_value), 32'h12CD);
    chk("movh_rob", 32'(out_rob_index), 32'd6);
    tick();
    chk("movh_done", 32'(out_valid), 32'd0);

    // MUL blocks issue for MUL_CYCLES cycles; a waiting ADD follows it out.
    drive(1'b1, 4'd8, 4'd7, 16'h0100, 16'h0101, 8'h00);
    tick();
    drive(1'b1, 4'd0, 4'd8, 16'd5, 16'd6, 8'h00);
    for (int k = 0; k < 3; k++) begin
      chk("mul_busy", 32'(in_ready), 32'd0);
      chk("mul_not_yet", 32'(out_valid), 32'd0);
      tick();
    end
    chk("mul_valid", 32'(out_valid), 32'd1);
    chk("mul_val", 32'(out_return_value), 32'h0100);
    chk("mul_rob", 32'(out_rob_index), 32'd7);
    chk("mul_ready_again", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("mul_add_gap", 32'(out_valid), 32'd0);
    tick();
    chk("mul_add_val", 32'(out_return_value), 32'd11);
    chk("mul_add_rob", 32'(out_rob_index), 32'd8);
    tick();
    chk("mul_add_done", 32'(out_valid), 32'd0);

    // Back-pressure: two fill the pipe, third waits, drain in order.
    out_ready = 1'b0;
    pops0 = n_pops;
    drive(1'b1, 4'd0, 4'd1, 16'd1, 16'h10, 8'h00);
    tick();
    drive(1'b1, 4'd0, 4'd2, 16'd2, 16'h10, 8'h00);
    chk("bp_ready_b", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 4'd0, 4'd3, 16'd3, 16'h10, 8'h00);
    chk("bp_full", 32'(in_ready), 32'd0);
    tick();
    chk("bp_full2", 32'(in_ready), 32'd0);
    chk("bp_head", 32'(out_rob_index), 32'd1);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (in_valid && in_ready) begin
        tick();
        in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
    chk("bp_pops", 32'(n_pops - pops0), 32'd3);

    // Flush during MUL with one result pending in the FIFO.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 4'd2, 16'd1, 16'd1, 8'h00);
    tick();
    drive(1'b1, 4'd8, 4'd4, 16'd3, 16'd3, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl_busy", 32'(in_ready), 32'd0);
    chk("fl_pending", 32'(out_valid), 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 4'd10, 16'd7, 16'd7, 8'h00);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    repeat (8) tick();
    chk("fl_nothing", 32'(out_valid), 32'd0);

    // Reset with a full FIFO and stalled output, then an undefined opcode.
    out_ready = 1'b0;
    drive(1'b1, 4'd0, 4'd1, 16'd4, 16'd4, 8'h00);
    tick();
    drive(1'b1, 4'd1, 4'd2, 16'd9, 16'd4, 8'h00);
    tick();
    in_valid = 1'b0;
    tick();
    chk("rf_full", 32'(in_ready), 32'd0);
    chk("rf_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    flush = 1'b1;
    in_valid = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("rf_out_valid", 32'(out_valid), 32'd0);
    chk("rf_rob", 32'(out_rob_index), 32'd0);
    chk("rf_val", 32'(out_return_value), 32'd0);
    chk("rf_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(1'b1, 4'hF, 4'd9, 16'h1234, 16'h0005, 8'h77);
    tick();
    in_valid = 1'b0;
    tick();
    chk("undef_valid", 32'(out_valid), 32'd1);
    chk("undef_val", 32'(out_return_value), 32'd0);
    chk("undef_rob", 32'(out_rob_index), 32'd9);
    tick();

    // Random traffic with occasional flushes.
    for (int k = 0; k < 600; k++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, op, 4'($urandom), 16'($urandom), 16'($urandom),
            8'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    tick();
    chk("rand_idle", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
